// File: rtl/fixed_dot3_sequencer_pkg.sv
// Shared definitions for the 3-component fixed-point dot-product sequencer:
// FSM encodings, 32-bit saturation bounds and the operand vector type.
`ifndef SCALE
`define SCALE 16
`endif

package fixed_dot3_sequencer_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [31:0] SAT_MAX = 32'h7FFF_FFFF;
  localparam logic [31:0] SAT_MIN = 32'h8000_0000;

  // The same bounds sign-extended, for comparing against the 64-bit accumulator
  localparam logic signed [63:0] SAT_MAX64 = 64'sh0000_0000_7FFF_FFFF;
  localparam logic signed [63:0] SAT_MIN64 = 64'shFFFF_FFFF_8000_0000;

  typedef struct packed {
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] z;
  } vec3_t;

  function automatic logic [31:0] vec3_pick(input vec3_t v, input logic [1:0] k);
    case (k)
      2'd0:    return v.x;
      2'd1:    return v.y;
      default: return v.z;
    endcase
  endfunction

endpackage

// File: rtl/fixed_sat64_to32.sv
// Combinational clamp of a signed 64-bit value into signed 32 bits, flagging
// when the clamp was applied. With P_SATURATE=0 it degenerates to truncation.
module fixed_sat64_to32
  import fixed_dot3_sequencer_pkg::*;
#(
  parameter bit P_SATURATE = 1'b1
) (
  input  logic [63:0] i_acc,
  output logic [31:0] o_res,
  output logic        o_sat
);

  logic w_over;
  logic w_under;

  assign w_over  = $signed(i_acc) > SAT_MAX64;
  assign w_under = $signed(i_acc) < SAT_MIN64;

  always_comb begin
    o_res = i_acc[31:0];
    o_sat = 1'b0;
    if (P_SATURATE) begin
      if (w_over) begin
        o_res = SAT_MAX;
        o_sat = 1'b1;
      end else if (w_under) begin
        o_res = SAT_MIN;
        o_sat = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fixed_dot3_sequencer.sv
// Issues three component pairs to the radix-4 multiplier, one at a time,
// accumulates the scaled 64-bit products and returns a 32-bit dot product.
//
//   state | meaning
//   IDLE  | oReady=1, waiting for a pair of vectors
//   ISSUE | one-cycle oMulInputReady pulse for component k
//   WAIT  | operands held, waiting for iMulOutputReady or timeout
//   DONE  | oValid=1, result held until iAck
module fixed_dot3_sequencer
  import fixed_dot3_sequencer_pkg::*;
#(
  parameter int unsigned P_TIMEOUT  = 15,
  parameter bit          P_SATURATE = 1'b1
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        iValid,
  output logic        oReady,
  input  logic [31:0] iAx,
  input  logic [31:0] iAy,
  input  logic [31:0] iAz,
  input  logic [31:0] iBx,
  input  logic [31:0] iBy,
  input  logic [31:0] iBz,
  output logic [31:0] oMulA,
  output logic [31:0] oMulB,
  output logic        oMulUnscaled,
  output logic        oMulInputReady,
  input  logic [63:0] iMulR,
  input  logic        iMulOutputReady,
  output logic        oValid,
  input  logic        iAck,
  output logic [31:0] oResult,
  output logic        oSaturated,
  output logic        oError
);

  logic [1:0]  r_state;
  vec3_t       r_a;
  vec3_t       r_b;
  logic [1:0]  r_k;
  logic [3:0]  r_cnt;
  logic [63:0] r_acc;
  logic [31:0] r_mul_a;
  logic [31:0] r_mul_b;
  logic [31:0] r_result;
  logic        r_sat;
  logic        r_err;

  logic [63:0] w_acc_next;
  logic [31:0] w_sat_res;
  logic        w_sat_flag;
  logic [3:0]  w_cnt_next;
  logic [1:0]  w_k_next;

  assign w_acc_next = r_acc + iMulR;
  assign w_cnt_next = r_cnt + 4'd1;
  assign w_k_next   = r_k + 2'd1;

  fixed_sat64_to32 #(
    .P_SATURATE(P_SATURATE)
  ) u_sat (
    .i_acc(w_acc_next),
    .o_res(w_sat_res),
    .o_sat(w_sat_flag)
  );

  // Operand registers are loaded on the transition into ISSUE so they are
  // already valid during the issue pulse and stay frozen through WAIT.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state  <= ST_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_k      <= '0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mul_a  <= '0;
      r_mul_b  <= '0;
      r_result <= '0;
      r_sat    <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (iValid) begin
            r_a     <= '{x: iAx, y: iAy, z: iAz};
            r_b     <= '{x: iBx, y: iBy, z: iBz};
            r_acc   <= '0;
            r_k     <= '0;
            r_mul_a <= iAx;
            r_mul_b <= iBx;
            r_state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_cnt   <= '0;
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          // A result arriving on the timeout cycle still wins.
          if (iMulOutputReady) begin
            r_acc <= w_acc_next;
            if (r_k == 2'd2) begin
              r_result <= w_sat_res;
              r_sat    <= w_sat_flag;
              r_err    <= 1'b0;
              r_state  <= ST_DONE;
            end else begin
              r_k     <= w_k_next;
              r_mul_a <= vec3_pick(r_a, w_k_next);
              r_mul_b <= vec3_pick(r_b, w_k_next);
              r_state <= ST_ISSUE;
            end
          end else begin
            r_cnt <= w_cnt_next;
            if (w_cnt_next == 4'(P_TIMEOUT)) begin
              r_result <= '0;
              r_sat    <= 1'b0;
              r_err    <= 1'b1;
              r_state  <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          if (iAck) begin
            r_sat   <= 1'b0;
            r_err   <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign oReady         = (r_state == ST_IDLE);
  assign oMulInputReady = (r_state == ST_ISSUE);
  assign oValid         = (r_state == ST_DONE);
  assign oMulA          = r_mul_a;
  assign oMulB          = r_mul_b;
  assign oMulUnscaled   = 1'b0;
  assign oResult        = r_result;
  assign oSaturated     = r_sat;
  assign oError         = r_err;

endmodule

// File: tb/tb_fixed_dot3_sequencer.sv
// Directed bench for fixed_dot3_sequencer with a 2-cycle model multiplier;
// a second instance with P_SATURATE=0 shares all stimulus.
`ifndef SCALE
`define SCALE 16
`endif

module tb_fixed_dot3_sequencer;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        iValid;
  logic [31:0] iAx, iAy, iAz, iBx, iBy, iBz;
  logic [63:0] iMulR;
  logic        iMulOutputReady;
  logic        iAck;

  logic        oReady, oMulUnscaled, oMulInputReady, oValid, oSaturated, oError;
  logic [31:0] oMulA, oMulB, oResult;

  logic        ns_oReady, ns_oMulUnscaled, ns_oMulInputReady, ns_oValid, ns_oSaturated, ns_oError;
  logic [31:0] ns_oMulA, ns_oMulB, ns_oResult;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 Clock = ~Clock;

  fixed_dot3_sequencer dut (
    .Clock(Clock), .Reset(Reset), .iValid(iValid), .oReady(oReady),
    .iAx(iAx), .iAy(iAy), .iAz(iAz), .iBx(iBx), .iBy(iBy), .iBz(iBz),
    .oMulA(oMulA), .oMulB(oMulB), .oMulUnscaled(oMulUnscaled),
    .oMulInputReady(oMulInputReady), .iMulR(iMulR), .iMulOutputReady(iMulOutputReady),
    .oValid(oValid), .iAck(iAck), .oResult(oResult), .oSaturated(oSaturated),
    .oError(oError)
  );

  fixed_dot3_sequencer #(.P_SATURATE(1'b0)) dut_ns (
    .Clock(Clock), .Reset(Reset), .iValid(iValid), .oReady(ns_oReady),
    .iAx(iAx), .iAy(iAy), .iAz(iAz), .iBx(iBx), .iBy(iBy), .iBz(iBz),
    .oMulA(ns_oMulA), .oMulB(ns_oMulB), .oMulUnscaled(ns_oMulUnscaled),
    .oMulInputReady(ns_oMulInputReady), .iMulR(iMulR), .iMulOutputReady(iMulOutputReady),
    .oValid(ns_oValid), .iAck(iAck), .oResult(ns_oResult), .oSaturated(ns_oSaturated),
    .oError(ns_oError)
  );

  // Model multiplier: strobe two cycles after the issue pulse, result is a
  // combinational function of the operands.
  logic [1:0]         r_pipe = 2'b00;
  logic               mul_en;
  logic signed [63:0] w_prod;

  always @(posedge Clock) r_pipe <= {r_pipe[0], oMulInputReady};
  assign iMulOutputReady = r_pipe[1] & mul_en;
  assign w_prod = $signed({{32{oMulA[31]}}, oMulA}) * $signed({{32{oMulB[31]}}, oMulB});
  assign iMulR  = w_prod >>> `SCALE;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present vectors, then count cycles until oValid, issue pulses, and any
  // operand change while waiting for the multiplier.
  task automatic run_vec(input logic [31:0] ax, ay, az, bx, by, bz,
                         output int lat, output int pulses, output int unstable);
    logic [31:0] ma, mb;
    ma = '0;
    mb = '0;
    iAx = ax; iAy = ay; iAz = az;
    iBx = bx; iBy = by; iBz = bz;
    iValid = 1'b1;
    tick();
    iValid = 1'b0;
    lat = 1;
    pulses = 0;
    unstable = 0;
    while (!oValid && lat < 40) begin
      if (oMulInputReady) begin
        pulses++;
        ma = oMulA;
        mb = oMulB;
      end else if (oMulA !== ma || oMulB !== mb) begin
        unstable++;
      end
      tick();
      lat++;
    end
  endtask

  task automatic do_ack();
    iAck = 1'b1;
    tick();
    iAck = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, pulses, unstable;
    Reset = 1'b1;
    iValid = 1'b0;
    iAck = 1'b0;
    mul_en = 1'b1;
    {iAx, iAy, iAz, iBx, iBy, iBz} = '0;
    tick();
    tick();
    Reset = 1'b0;

    check("rst_ready",  64'(oReady), 64'd1);
    check("rst_valid",  64'(oValid), 64'd0);
    check("rst_issue",  64'(oMulInputReady), 64'd0);
    check("rst_mula",   64'(oMulA), 64'd0);
    check("rst_result", 64'(oResult), 64'd0);
    check("rst_sat",    64'(oSaturated), 64'd0);
    check("rst_err",    64'(oError), 64'd0);
    check("unscaled",   64'(oMulUnscaled), 64'd0);

    // (1,2,3).(4,5,6) = 32.0
    run_vec(32'h0001_0000, 32'h0002_0000, 32'h0003_0000,
            32'h0004_0000, 32'h0005_0000, 32'h0006_0000, lat, pulses, unstable);
    check("basic_lat",    64'(lat), 64'd10);
    check("basic_pulses", 64'(pulses), 64'd3);
    check("basic_stable", 64'(unstable), 64'd0);
    check("basic_result", 64'(oResult), 64'h0020_0000);
    check("basic_sat",    64'(oSaturated), 64'd0);
    check("basic_err",    64'(oError), 64'd0);

    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_valid",  64'(oValid), 64'd1);
      check("bp_result", 64'(oResult), 64'h0020_0000);
      check("bp_ready",  64'(oReady), 64'd0);
    end
    do_ack();
    check("ack_ready", 64'(oReady), 64'd1);
    check("ack_valid", 64'(oValid), 64'd0);

    // (-1.5,2,0).(2,-0.5,7) = -4.0, presented the cycle after the ack
    run_vec(32'hFFFE_8000, 32'h0002_0000, 32'h0000_0000,
            32'h0002_0000, 32'hFFFF_8000, 32'h0007_0000, lat, pulses, unstable);
    check("b2b_lat",     64'(lat), 64'd10);
    check("sign_stable", 64'(unstable), 64'd0);
    check("sign_result", 64'(oResult), 64'hFFFC_0000);
    check("sign_sat",    64'(oSaturated), 64'd0);
    do_ack();

    // Positive overflow; iAck held high through the run must not disturb it
    iAck = 1'b1;
    run_vec(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h0000_0000,
            32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h0000_0000, lat, pulses, unstable);
    iAck = 1'b0;
    check("satp_lat",       64'(lat), 64'd10);
    check("satp_result",    64'(oResult), 64'h7FFF_FFFF);
    check("satp_sat",       64'(oSaturated), 64'd1);
    check("satp_ns_result", 64'(ns_oResult), 64'hFFFE_0000);
    check("satp_ns_sat",    64'(ns_oSaturated), 64'd0);
    do_ack();
    check("satp_ack_sat",   64'(oSaturated), 64'd0);

    // Negative overflow
    run_vec(32'h8000_0000, 32'h8000_0000, 32'h0000_0000,
            32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h0000_0000, lat, pulses, unstable);
    check("satn_result",    64'(oResult), 64'h8000_0000);
    check("satn_sat",       64'(oSaturated), 64'd1);
    check("satn_ns_result", 64'(ns_oResult), 64'h0001_0000);
    check("satn_ns_sat",    64'(ns_oSaturated), 64'd0);
    do_ack();

    // Multiplier never answers: 15 WAIT cycles after the issue in cycle 1
    mul_en = 1'b0;
    run_vec(32'h0001_0000, 32'h0002_0000, 32'h0003_0000,
            32'h0004_0000, 32'h0005_0000, 32'h0006_0000, lat, pulses, unstable);
    check("to_lat",    64'(lat), 64'd17);
    check("to_pulses", 64'(pulses), 64'd1);
    check("to_err",    64'(oError), 64'd1);
    check("to_result", 64'(oResult), 64'd0);
    check("to_sat",    64'(oSaturated), 64'd0);
    do_ack();
    mul_en = 1'b1;
    check("to_ack_ready", 64'(oReady), 64'd1);
    check("to_ack_err",   64'(oError), 64'd0);

    // Reset while waiting on component y
    iAx = 32'h0001_0000; iAy = 32'h0002_0000; iAz = 32'h0003_0000;
    iBx = 32'h0004_0000; iBy = 32'h0005_0000; iBz = 32'h0006_0000;
    iValid = 1'b1;
    tick();
    iValid = 1'b0;
    tick();
    tick();
    tick();
    check("y_issue", 64'(oMulInputReady), 64'd1);
    check("y_mula",  64'(oMulA), 64'h0002_0000);
    check("y_mulb",  64'(oMulB), 64'h0005_0000);
    tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check("mr_ready", 64'(oReady), 64'd1);
    check("mr_valid", 64'(oValid), 64'd0);
    check("mr_issue", 64'(oMulInputReady), 64'd0);
    check("mr_mula",  64'(oMulA), 64'd0);
    tick();
    check("stale_ready", 64'(oReady), 64'd1);
    check("stale_issue", 64'(oMulInputReady), 64'd0);
    check("stale_valid", 64'(oValid), 64'd0);

    // (0.5,1,-1).(2,3,1) = 3.0
    run_vec(32'h0000_8000, 32'h0001_0000, 32'hFFFF_0000,
            32'h0002_0000, 32'h0003_0000, 32'h0001_0000, lat, pulses, unstable);
    check("post_lat",    64'(lat), 64'd10);
    check("post_result", 64'(oResult), 64'h0003_0000);
    check("post_err",    64'(oError), 64'd0);
    do_ack();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
